// File: rtl/io_port_hub.sv
// I/O hub between proc_fx and NUIOIN input / NUIOOU output handshake channels.
// Optional macro IO_PORT_HUB_STALL_EN adds proc_stall instead of drop-and-flag.
module io_port_hub #(
    parameter int NUBITS = 31,
    parameter int NUIOIN = 4,
    parameter int NUIOOU = 4,
    parameter int ODEPTH = 4,
    localparam int IAW = (NUIOIN > 1) ? $clog2(NUIOIN) : 1,
    localparam int OAW = (NUIOOU > 1) ? $clog2(NUIOOU) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [IAW-1:0]           proc_addr_in,
    input  logic                     proc_req_in,
    output logic [NUBITS-1:0]        proc_in_data,
    input  logic [OAW-1:0]           proc_addr_out,
    input  logic                     proc_out_en,
    input  logic [NUBITS-1:0]        proc_out_data,
    input  logic [NUIOIN*NUBITS-1:0] in_data,
    input  logic [NUIOIN-1:0]        in_valid,
    output logic [NUIOIN-1:0]        in_ready,
    output logic [NUIOOU*NUBITS-1:0] out_data,
    output logic [NUIOOU-1:0]        out_valid,
    input  logic [NUIOOU-1:0]        out_ready,
    output logic [NUIOIN-1:0]        in_underrun,
    output logic [NUIOOU-1:0]        out_overflow,
    input  logic                     err_clr
`ifdef IO_PORT_HUB_STALL_EN
    ,
    output logic                     proc_stall
`endif
);

    localparam int PW = $clog2(ODEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(ODEPTH);

    logic [NUBITS-1:0] hold_data [NUIOIN];
    logic [NUIOIN-1:0] underrun_try;
    logic [NUIOOU-1:0] overflow_try;
    logic              in_sel_ok;
    logic              out_sel_ok;
    logic              stall;

    assign in_sel_ok  = (32'(proc_addr_in) < NUIOIN);
    assign out_sel_ok = (32'(proc_addr_out) < NUIOOU);

    // Zero-latency read path: proc_fx samples this in the strobe cycle.
    always_comb begin
        proc_in_data = '0;
        if (in_sel_ok) begin
            proc_in_data = hold_data[proc_addr_in];
        end
    end

`ifdef IO_PORT_HUB_STALL_EN
    assign stall      = (|underrun_try) | (|overflow_try);
    assign proc_stall = stall;
`else
    assign stall = 1'b0;
`endif

    for (genvar gi = 0; gi < NUIOIN; gi++) begin : g_in
        logic [NUBITS-1:0] hold_reg;
        logic              valid_reg;
        logic              underrun_reg;
        logic              rd_sel;
        logic              capture;

        assign rd_sel            = proc_req_in & in_sel_ok & (32'(proc_addr_in) == gi);
        assign capture           = in_valid[gi] & in_ready[gi];
        assign underrun_try[gi]  = rd_sel & ~valid_reg;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                hold_reg     <= '0;
                valid_reg    <= 1'b0;
                underrun_reg <= 1'b0;
            end else begin
                // Capture needs an empty holder, so it never races a consuming read.
                if (capture) begin
                    hold_reg  <= in_data[gi*NUBITS +: NUBITS];
                    valid_reg <= 1'b1;
                end else if (rd_sel && !stall) begin
                    valid_reg <= 1'b0;
                end
                if (underrun_try[gi] && !stall) begin
                    underrun_reg <= 1'b1;
                end else if (err_clr) begin
                    underrun_reg <= 1'b0;
                end
            end
        end

        assign hold_data[gi]   = hold_reg;
        assign in_ready[gi]    = rst & ~valid_reg;
        assign in_underrun[gi] = underrun_reg;
    end

    for (genvar gi = 0; gi < NUIOOU; gi++) begin : g_out
        logic [NUBITS-1:0] mem_reg [ODEPTH];
        logic [PW-1:0]     wr_ptr_reg;
        logic [PW-1:0]     rd_ptr_reg;
        logic [PW:0]       count_reg;
        logic              overflow_reg;
        logic              wr_sel;
        logic              full;
        logic              pop;
        logic              push;

        assign wr_sel            = proc_out_en & out_sel_ok & (32'(proc_addr_out) == gi);
        assign full              = (count_reg == FULL_CNT);
        assign pop               = (count_reg != '0) & out_ready[gi];
        // A same-cycle pop frees the slot, so a write into a full FIFO still lands.
        assign push              = wr_sel & (~full | pop);
        assign overflow_try[gi]  = wr_sel & full & ~pop;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int k = 0; k < ODEPTH; k++) begin
                    mem_reg[k] <= '0;
                end
                wr_ptr_reg   <= '0;
                rd_ptr_reg   <= '0;
                count_reg    <= '0;
                overflow_reg <= 1'b0;
            end else begin
                if (push) begin
                    mem_reg[wr_ptr_reg] <= proc_out_data;
                    wr_ptr_reg          <= wr_ptr_reg + PW'(1);
                end
                if (pop) begin
                    rd_ptr_reg <= rd_ptr_reg + PW'(1);
                end
                if (push && !pop) begin
                    count_reg <= count_reg + (PW+1)'(1);
                end else if (pop && !push) begin
                    count_reg <= count_reg - (PW+1)'(1);
                end
                if (overflow_try[gi] && !stall) begin
                    overflow_reg <= 1'b1;
                end else if (err_clr) begin
                    overflow_reg <= 1'b0;
                end
            end
        end

        assign out_data[gi*NUBITS +: NUBITS] = mem_reg[rd_ptr_reg];
        assign out_valid[gi]                 = (count_reg != '0);
        assign out_overflow[gi]              = overflow_reg;
    end

endmodule

// File: tb/tb_io_port_hub.sv
// Directed self-checking bench for io_port_hub (default parameters).
// Stall-specific steps run only when IO_PORT_HUB_STALL_EN is defined.
module tb_io_port_hub;
    localparam int NB = 31;
    localparam int NI = 4;
    localparam int NO = 4;
`ifdef IO_PORT_HUB_STALL_EN
    localparam bit STALL = 1'b1;
`else
    localparam bit STALL = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      proc_addr_in;
    logic            proc_req_in;
    logic [NB-1:0]   proc_in_data;
    logic [1:0]      proc_addr_out;
    logic            proc_out_en;
    logic [NB-1:0]   proc_out_data;
    logic [NI*NB-1:0] in_data;
    logic [NI-1:0]   in_valid;
    logic [NI-1:0]   in_ready;
    logic [NO*NB-1:0] out_data;
    logic [NO-1:0]   out_valid;
    logic [NO-1:0]   out_ready;
    logic [NI-1:0]   in_underrun;
    logic [NO-1:0]   out_overflow;
    logic            err_clr;
`ifdef IO_PORT_HUB_STALL_EN
    logic            proc_stall;
`endif

    int errors = 0;
    int checks = 0;

    io_port_hub dut (
        .clk          (clk),
        .rst          (rst),
        .proc_addr_in (proc_addr_in),
        .proc_req_in  (proc_req_in),
        .proc_in_data (proc_in_data),
        .proc_addr_out(proc_addr_out),
        .proc_out_en  (proc_out_en),
        .proc_out_data(proc_out_data),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .in_underrun  (in_underrun),
        .out_overflow (out_overflow),
        .err_clr      (err_clr)
`ifdef IO_PORT_HUB_STALL_EN
        ,
        .proc_stall   (proc_stall)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [NB-1:0] out_word(input int j);
        return out_data[j*NB +: NB];
    endfunction

    initial begin
        int exp_q [4];
        exp_q = '{2, 3, 4, 7};

        rst           = 1'b0;
        proc_addr_in  = '0;
        proc_req_in   = 1'b0;
        proc_addr_out = '0;
        proc_out_en   = 1'b0;
        proc_out_data = '0;
        in_data       = {31'h40, 31'h30, 31'h20, 31'h10};
        in_valid      = 4'hF;
        out_ready     = '0;
        err_clr       = 1'b0;

        // Reset with producers valid
        tick();
        tick();
        chk("rst_in_ready", in_ready, 4'h0);
        chk("rst_out_valid", out_valid, 4'h0);
        chk("rst_underrun", in_underrun, 4'h0);
        chk("rst_overflow", out_overflow, 4'h0);
        chk("rst_proc_data", proc_in_data, 31'h0);
        chk("rst_out_data", out_data, '0);

        rst = 1'b1;
        #1;
        chk("rel_in_ready", in_ready, 4'hF);
        in_valid = 4'h0;
        tick();
        chk("idle_in_ready", in_ready, 4'hF);

        // Channel 2 capture then processor read
        in_data[2*NB +: NB] = 31'h123;
        in_valid = 4'b0100;
        tick();
        in_valid = 4'h0;
        chk("cap2_in_ready", in_ready, 4'b1011);
        proc_addr_in = 2'd2;
        proc_req_in  = 1'b1;
        #1;
        chk("rd2_data", proc_in_data, 31'h123);
        tick();
        proc_req_in = 1'b0;
        chk("rd2_in_ready", in_ready, 4'hF);
        chk("rd2_keep_data", proc_in_data, 31'h123);
        chk("rd2_underrun", in_underrun, 4'h0);

        // Empty read of channel 1
        proc_addr_in = 2'd1;
        proc_req_in  = 1'b1;
        #1;
        chk("rd1_empty_data", proc_in_data, 31'h0);
        tick();
        proc_req_in = 1'b0;
        chk("rd1_underrun", in_underrun, STALL ? 4'b0000 : 4'b0010);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("clr_underrun", in_underrun, 4'h0);

        // Set wins over same-cycle clear
        proc_req_in = 1'b1;
        err_clr     = 1'b1;
        tick();
        proc_req_in = 1'b0;
        err_clr     = 1'b0;
        chk("setwins_underrun", in_underrun, STALL ? 4'b0000 : 4'b0010);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("clr2_underrun", in_underrun, 4'h0);

        // Five writes into ch3 with the consumer stalled
        proc_addr_out = 2'd3;
        for (int k = 1; k <= 5; k++) begin
            proc_out_en   = 1'b1;
            proc_out_data = NB'(k);
            tick();
        end
        proc_out_en = 1'b0;
        chk("ch3_out_valid", out_valid, 4'b1000);
        chk("ch3_overflow", out_overflow, STALL ? 4'b0000 : 4'b1000);
        out_ready = 4'b1000;
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("ch3_drain%0d", k), out_word(3), 64'(k));
            tick();
        end
        chk("ch3_empty", out_valid, 4'b0000);
        out_ready = '0;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("clr_overflow", out_overflow, 4'h0);

        // Full ch0: push and pop in the same cycle
        proc_addr_out = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            proc_out_en   = 1'b1;
            proc_out_data = NB'(k);
            tick();
        end
        out_ready     = 4'b0001;
        proc_out_data = 31'h7;
        #1;
        chk("ch0_head", out_word(0), 31'h1);
        tick();
        proc_out_en = 1'b0;
        chk("ch0_no_ovf", out_overflow, 4'h0);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("ch0_drain%0d", k), out_word(0), 64'(exp_q[k]));
            tick();
        end
        chk("ch0_empty", out_valid, 4'b0000);

        // Push into empty ch1 with consumer ready
        out_ready     = 4'b0010;
        proc_addr_out = 2'd1;
        proc_out_data = 31'h9;
        proc_out_en   = 1'b1;
        #1;
        chk("ch1_pre_valid", out_valid, 4'b0000);
        tick();
        proc_out_en = 1'b0;
        chk("ch1_valid", out_valid, 4'b0010);
        chk("ch1_word", out_word(1), 31'h9);
        tick();
        chk("ch1_popped", out_valid, 4'b0000);
        out_ready = '0;

        // Capture and empty read on ch0 in the same cycle
        in_data[0*NB +: NB] = 31'hAA;
        in_valid     = 4'b0001;
        proc_addr_in = 2'd0;
        proc_req_in  = 1'b1;
        #1;
        chk("race_stale", proc_in_data, 31'h0);
        tick();
        in_valid = 4'h0;
        chk("race_underrun", in_underrun, STALL ? 4'b0000 : 4'b0001);
        chk("race_in_ready", in_ready, 4'b1110);
        chk("race_new_data", proc_in_data, 31'hAA);
        tick();
        proc_req_in = 1'b0;
        chk("race_consumed", in_ready, 4'hF);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;

`ifdef IO_PORT_HUB_STALL_EN
        // Stalled read of empty ch0, then feed and retry
        proc_addr_in = 2'd0;
        proc_req_in  = 1'b1;
        #1;
        chk("stall_rd", proc_stall, 1'b1);
        tick();
        chk("stall_no_unr", in_underrun, 4'h0);
        in_data[0*NB +: NB] = 31'h55;
        in_valid = 4'b0001;
        tick();
        in_valid = 4'h0;
        chk("stall_release", proc_stall, 1'b0);
        chk("stall_data", proc_in_data, 31'h55);
        tick();
        proc_req_in = 1'b0;
        chk("stall_consumed", in_ready, 4'hF);

        // Overflowing push stalls instead of dropping
        proc_addr_out = 2'd2;
        for (int k = 1; k <= 4; k++) begin
            proc_out_en   = 1'b1;
            proc_out_data = NB'(k);
            tick();
        end
        proc_out_data = 31'h5;
        #1;
        chk("stall_wr", proc_stall, 1'b1);
        tick();
        proc_out_en = 1'b0;
        chk("stall_no_ovf", out_overflow, 4'h0);
        chk("stall_head", out_word(2), 31'h1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
